// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences a single-ported, fixed-latency unified memory shared
// by the instruction fetch stage and the data memory stage. One requester is
// granted at a time, the access is held for LATENCY cycles, and the returned
// data is presented together with a one-cycle done pulse.
module mem_arbiter #(
    parameter int LATENCY = 4,   // legal range 2..15
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active-low

    // Instruction fetch side
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,

    // Data side
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,

    // Pipeline control
    output logic              stall_if,
    output logic              stall_mem,
    output logic              err,

    // Memory macro
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        IACC,   // instruction access in flight
        DACC    // data access in flight
    } state_t;

    typedef enum logic {
        GRANT_IF,
        GRANT_DATA
    } grant_t;

    // Value of cnt during the final cycle of an access.
    localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

    state_t     state;
    grant_t     last_grant;
    logic [3:0] cnt;
    logic       squash;     // fetch in flight was flushed; drop its result

    logic       if_eligible;
    logic       dm_eligible;
    logic       grant_if;
    logic       grant_data;

    // Request qualification and arbitration, evaluated while IDLE.
    // A requester is not eligible in the cycle its own done pulse is high,
    // which lets the other side win the back-to-back slot. On a tie, the side
    // that was not granted last time wins so neither can starve.
    always_comb begin
        // NOTE: every signal gets a default first so no path through this block
        // leaves it unassigned, which would otherwise infer a latch.
        if_eligible = 1'b0;
        dm_eligible = 1'b0;
        grant_if    = 1'b0;
        grant_data  = 1'b0;

        if_eligible = if_req & ~flush & ~if_done;
        dm_eligible = (dm_rd ^ dm_wr) & ~dm_done;

        if (dm_eligible && (!if_eligible || last_grant != GRANT_DATA)) begin
            grant_data = 1'b1;
        end else if (if_eligible) begin
            grant_if = 1'b1;
        end
    end

    // Stalls follow the requests directly: a stage holds until it sees done.
    assign stall_if  = if_req & ~if_done;
    assign stall_mem = (dm_rd | dm_wr) & ~dm_done;

    // Main sequencer: grant, hold the access for LATENCY cycles, return data.
    // mem_wr/mem_addr/mem_wdata double as the capture registers, so they stay
    // constant for the whole access and return to zero in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= GRANT_IF;
            cnt        <= '0;
            squash     <= 1'b0;
            if_rdata   <= '0;
            if_done    <= 1'b0;
            dm_rdata   <= '0;
            dm_done    <= 1'b0;
            err        <= 1'b0;
            mem_en     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            // Pulses default low and are raised only in the cycle they apply.
            if_done <= 1'b0;
            dm_done <= 1'b0;
            err     <= 1'b0;

            case (state)
                IDLE: begin
                    cnt    <= '0;
                    squash <= 1'b0;
                    // Conflicting read+write is never granted; flag it instead.
                    err    <= dm_rd & dm_wr;

                    if (grant_data) begin
                        state      <= DACC;
                        last_grant <= GRANT_DATA;
                        mem_en     <= 1'b1;
                        mem_wr     <= dm_wr;
                        mem_addr   <= dm_addr;
                        mem_wdata  <= dm_wdata;
                    end else if (grant_if) begin
                        state      <= IACC;
                        last_grant <= GRANT_IF;
                        mem_en     <= 1'b1;
                        mem_wr     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                    end
                end

                IACC: begin
                    // The memory cannot abort, so a flush only marks the
                    // result for discard.
                    if (flush) begin
                        squash <= 1'b1;
                    end

                    if (cnt == LAST_CNT) begin
                        // A flush arriving in the very last cycle still counts.
                        if (!(squash || flush)) begin
                            if_rdata <= mem_rdata;
                            if_done  <= 1'b1;
                        end
                        state     <= IDLE;
                        cnt       <= '0;
                        squash    <= 1'b0;
                        mem_en    <= 1'b0;
                        mem_wr    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end

                DACC: begin
                    if (cnt == LAST_CNT) begin
                        // Writes complete with a done pulse but leave the
                        // load data register untouched.
                        if (!mem_wr) begin
                            dm_rdata <= mem_rdata;
                        end
                        dm_done   <= 1'b1;
                        state     <= IDLE;
                        cnt       <= '0;
                        mem_en    <= 1'b0;
                        mem_wr    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with LATENCY=4.
// Cycle k of a step starts at posedge k; inputs for cycle k are driven 1ns
// after that edge and outputs are compared 1ns later.
module tb_mem_arbiter;

    localparam int LATENCY = 4;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              flush;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              dm_rd;
    logic              dm_wr;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;
    logic              stall_if;
    logic              stall_mem;
    logic              err;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int n_cmp;
    int n_err;

    mem_arbiter #(
        .LATENCY (LATENCY),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .flush     (flush),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .dm_rd     (dm_rd),
        .dm_wr     (dm_wr),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_done   (dm_done),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .err       (err),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        flush     = 1'b0;
        dm_rd     = 1'b0;
        dm_wr     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;

        // ---------------- Reset state ----------------
        #1 rst = 1'b0;
        #2;
        check("rst_if_done",   32'(if_done),   32'd0);
        check("rst_dm_done",   32'(dm_done),   32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_mem_en",    32'(mem_en),    32'd0);
        check("rst_mem_wr",    32'(mem_wr),    32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_if_rdata",  32'(if_rdata),  32'd0);
        check("rst_dm_rdata",  32'(dm_rdata),  32'd0);
        check("rst_stall_if",  32'(stall_if),  32'd0);
        check("rst_stall_mem", 32'(stall_mem), 32'd0);
        // A request while held in reset must not be granted.
        if_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_mem_en", 32'(mem_en), 32'd0);
        if_req = 1'b0;
        do_reset();

        // ---------------- T1: single fetch ----------------
        for (int k = 0; k <= 6; k++) begin
            tk();
            if (k == 0) begin if_req = 1'b1; if_addr = 16'h0010; mem_rdata = 16'hA5A5; end
            if (k == 6) if_req = 1'b0;
            #1;
            check($sformatf("t1_mem_en_c%0d", k),   32'(mem_en),   32'(k >= 1 && k <= 4));
            check($sformatf("t1_stall_if_c%0d", k), 32'(stall_if), 32'(k <= 4));
            check($sformatf("t1_if_done_c%0d", k),  32'(if_done),  32'(k == 5));
            if (k == 1 || k == 4) begin
                check($sformatf("t1_mem_addr_c%0d", k), 32'(mem_addr), 32'h0010);
                check($sformatf("t1_mem_wr_c%0d", k),   32'(mem_wr),   32'd0);
            end
            if (k == 5) check("t1_if_rdata", 32'(if_rdata), 32'hA5A5);
        end

        // ---------------- T2: simultaneous requests, alternation ----------------
        do_reset();
        for (int k = 0; k <= 21; k++) begin
            tk();
            if (k == 0) begin
                if_req = 1'b1; if_addr = 16'h0020;
                dm_rd  = 1'b1; dm_addr = 16'h0300;
                mem_rdata = 16'h1111;
            end
            if (k == 5)  mem_rdata = 16'h2222;
            if (k == 6)  dm_addr = 16'h0301;
            if (k == 11) begin if_addr = 16'h0021; mem_rdata = 16'h3333; end
            if (k == 16) dm_rd = 1'b0;
            if (k == 21) if_req = 1'b0;
            #1;
            case (k)
                0: begin
                    check("t2_stall_if_c0",  32'(stall_if),  32'd1);
                    check("t2_stall_mem_c0", 32'(stall_mem), 32'd1);
                end
                1: begin
                    check("t2_mem_en_c1",   32'(mem_en),   32'd1);
                    check("t2_mem_addr_c1", 32'(mem_addr), 32'h0300);
                end
                5: begin
                    check("t2_dm_done_c5",   32'(dm_done),   32'd1);
                    check("t2_dm_rdata_c5",  32'(dm_rdata),  32'h1111);
                    check("t2_stall_mem_c5", 32'(stall_mem), 32'd0);
                    check("t2_stall_if_c5",  32'(stall_if),  32'd1);
                    check("t2_if_done_c5",   32'(if_done),   32'd0);
                    check("t2_mem_en_c5",    32'(mem_en),    32'd0);
                end
                6: begin
                    check("t2_mem_en_c6",   32'(mem_en),   32'd1);
                    check("t2_mem_addr_c6", 32'(mem_addr), 32'h0020);
                    check("t2_dm_done_c6",  32'(dm_done),  32'd0);
                end
                10: begin
                    check("t2_if_done_c10",  32'(if_done),  32'd1);
                    check("t2_if_rdata_c10", 32'(if_rdata), 32'h2222);
                    check("t2_stall_if_c10", 32'(stall_if), 32'd0);
                end
                11: check("t2_mem_addr_c11", 32'(mem_addr), 32'h0301);
                15: begin
                    check("t2_dm_done_c15",  32'(dm_done),  32'd1);
                    check("t2_dm_rdata_c15", 32'(dm_rdata), 32'h3333);
                end
                16: check("t2_mem_addr_c16", 32'(mem_addr), 32'h0021);
                20: begin
                    check("t2_if_done_c20",  32'(if_done),  32'd1);
                    check("t2_if_rdata_c20", 32'(if_rdata), 32'h3333);
                end
                21: check("t2_mem_en_c21", 32'(mem_en), 32'd0);
                default: ;
            endcase
        end

        // ---------------- T3: data write ----------------
        for (int k = 0; k <= 6; k++) begin
            tk();
            if (k == 0) begin
                dm_wr = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h1234;
                mem_rdata = 16'hBEEF;
            end
            if (k == 6) dm_wr = 1'b0;
            #1;
            if (k >= 1 && k <= 4) begin
                check($sformatf("t3_mem_en_c%0d", k),    32'(mem_en),    32'd1);
                check($sformatf("t3_mem_wr_c%0d", k),    32'(mem_wr),    32'd1);
                check($sformatf("t3_mem_addr_c%0d", k),  32'(mem_addr),  32'h0200);
                check($sformatf("t3_mem_wdata_c%0d", k), 32'(mem_wdata), 32'h1234);
            end
            check($sformatf("t3_dm_done_c%0d", k), 32'(dm_done), 32'(k == 5));
            if (k == 5) begin
                check("t3_dm_rdata_kept", 32'(dm_rdata), 32'h3333);
                check("t3_mem_wr_c5",     32'(mem_wr),   32'd0);
            end
        end

        // ---------------- T3b: tie after a data grant goes to fetch ----------------
        for (int k = 0; k <= 11; k++) begin
            tk();
            if (k == 0) begin
                if_req = 1'b1; if_addr = 16'h0044;
                dm_rd  = 1'b1; dm_addr = 16'h0400;
            end
            if (k == 6)  if_req = 1'b0;
            if (k == 11) dm_rd = 1'b0;
            #1;
            case (k)
                1: begin
                    check("t3b_mem_addr_c1", 32'(mem_addr), 32'h0044);
                    check("t3b_mem_wr_c1",   32'(mem_wr),   32'd0);
                end
                5: begin
                    check("t3b_if_done_c5",  32'(if_done),  32'd1);
                    check("t3b_if_rdata_c5", 32'(if_rdata), 32'hBEEF);
                end
                6:  check("t3b_mem_addr_c6", 32'(mem_addr), 32'h0400);
                10: begin
                    check("t3b_dm_done_c10",  32'(dm_done),  32'd1);
                    check("t3b_dm_rdata_c10", 32'(dm_rdata), 32'hBEEF);
                end
                default: ;
            endcase
        end

        // ---------------- T4a: flush in IDLE blocks the fetch grant ----------------
        for (int k = 0; k <= 7; k++) begin
            tk();
            if (k == 0) begin if_req = 1'b1; if_addr = 16'h0060; flush = 1'b1; mem_rdata = 16'h6060; end
            if (k == 1) flush = 1'b0;
            if (k == 7) if_req = 1'b0;
            #1;
            case (k)
                1: check("t4a_mem_en_c1", 32'(mem_en), 32'd0);
                2: begin
                    check("t4a_mem_en_c2",   32'(mem_en),   32'd1);
                    check("t4a_mem_addr_c2", 32'(mem_addr), 32'h0060);
                end
                6: begin
                    check("t4a_if_done_c6",  32'(if_done),  32'd1);
                    check("t4a_if_rdata_c6", 32'(if_rdata), 32'h6060);
                end
                default: ;
            endcase
        end

        // ---------------- T4: flush during IACC squashes the fetch ----------------
        for (int k = 0; k <= 11; k++) begin
            tk();
            if (k == 0)  begin if_req = 1'b1; if_addr = 16'h0050; mem_rdata = 16'h0BAD; end
            if (k == 2)  flush = 1'b1;
            if (k == 3)  begin flush = 1'b0; if_addr = 16'h0080; end
            if (k == 5)  mem_rdata = 16'hC0DE;
            if (k == 11) if_req = 1'b0;
            #1;
            case (k)
                2: check("t4_mem_addr_c2", 32'(mem_addr), 32'h0050);
                4: begin
                    check("t4_mem_en_c4",   32'(mem_en),   32'd1);
                    check("t4_mem_addr_c4", 32'(mem_addr), 32'h0050);
                end
                5: begin
                    check("t4_if_done_c5",  32'(if_done),  32'd0);
                    check("t4_if_rdata_c5", 32'(if_rdata), 32'h6060);
                    check("t4_mem_en_c5",   32'(mem_en),   32'd0);
                    check("t4_stall_if_c5", 32'(stall_if), 32'd1);
                end
                6: begin
                    check("t4_mem_en_c6",   32'(mem_en),   32'd1);
                    check("t4_mem_addr_c6", 32'(mem_addr), 32'h0080);
                end
                10: begin
                    check("t4_if_done_c10",  32'(if_done),  32'd1);
                    check("t4_if_rdata_c10", 32'(if_rdata), 32'hC0DE);
                end
                default: ;
            endcase
        end

        // ---------------- T5: illegal read+write ----------------
        for (int k = 0; k <= 3; k++) begin
            tk();
            if (k == 0) begin dm_rd = 1'b1; dm_wr = 1'b1; end
            if (k == 2) begin dm_rd = 1'b0; dm_wr = 1'b0; end
            #1;
            check($sformatf("t5_err_c%0d", k),    32'(err),    32'(k == 1 || k == 2));
            check($sformatf("t5_mem_en_c%0d", k), 32'(mem_en), 32'd0);
            if (k == 0) check("t5_stall_mem_c0", 32'(stall_mem), 32'd1);
            if (k == 3) check("t5_dm_done_c3",   32'(dm_done),   32'd0);
        end

        // ---------------- T6: reset in the middle of DACC ----------------
        for (int k = 0; k <= 2; k++) begin
            tk();
            if (k == 0) begin dm_rd = 1'b1; dm_addr = 16'h0600; mem_rdata = 16'h7777; end
            #1;
            if (k == 2) begin
                check("t6_mem_en_pre",   32'(mem_en),   32'd1);
                check("t6_mem_addr_pre", 32'(mem_addr), 32'h0600);
            end
        end
        #1;
        rst   = 1'b0;
        dm_rd = 1'b0;
        #1;
        check("t6_mem_en_rst",   32'(mem_en),   32'd0);
        check("t6_mem_addr_rst", 32'(mem_addr), 32'd0);
        check("t6_dm_rdata_rst", 32'(dm_rdata), 32'd0);
        check("t6_if_rdata_rst", 32'(if_rdata), 32'd0);
        check("t6_dm_done_rst",  32'(dm_done),  32'd0);
        check("t6_stall_mem_rst", 32'(stall_mem), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tk();
            #1;
            check($sformatf("t6_dm_done_after_c%0d", k), 32'(dm_done), 32'd0);
            check($sformatf("t6_mem_en_after_c%0d", k),  32'(mem_en),  32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
